// File: rtl/perf_event_counter_pkg.sv
// Shared definitions for the performance event counter: read-select codes
// and the run/read state encodings.
package perf_event_counter_pkg;

  localparam logic [1:0] SEL_CYCLE  = 2'd0;
  localparam logic [1:0] SEL_STALL  = 2'd1;
  localparam logic [1:0] SEL_FLUSH  = 2'd2;
  localparam logic [1:0] SEL_RETIRE = 2'd3;

  localparam int NUM_EVENTS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } run_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_ACK  = 1'b1
  } rd_state_t;

  // A load-use stall is only a real stall when no control transfer is
  // squashing the same slot.
  function automatic logic is_load_use_stall(input logic hazard,
                                             input logic jump,
                                             input logic branch);
    return hazard & ~jump & ~branch;
  endfunction

endpackage

// File: rtl/perf_event_counter_sat_counter.sv
// Saturating event counter with a sticky overflow flag; clear wins over
// increment.
module perf_sat_counter
  import perf_event_counter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             w_saturated;

  assign w_saturated = (r_count == {CNT_W{1'b1}});

  // The flag sets on the first increment attempt that finds the counter full.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clr_i) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (inc_i) begin
      if (w_saturated) begin
        r_ovf <= 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign count_o = r_count;
  assign ovf_o   = r_ovf;

endmodule

// File: rtl/perf_event_counter.sv
// Performance monitor beside the CPU pipeline: run FSM, event decode, four
// saturating counters and a one-cycle request/ack read port.
module perf_event_counter
  import perf_event_counter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             hazard_i,
  input  logic             jump_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic             freeze_i,
  input  logic             clear_i,
  input  logic             rd_req_i,
  input  logic [1:0]       rd_sel_i,
  output logic             rd_ack_o,
  output logic [CNT_W-1:0] rd_data_o,
  output logic [3:0]       overflow_o
);

  run_state_t       r_run_state;
  rd_state_t        r_rd_state;
  logic             r_rd_ack;
  logic [CNT_W-1:0] r_rd_data;

  logic                   w_count_en;
  logic [NUM_EVENTS-1:0]  w_inc;
  logic [NUM_EVENTS-1:0]  w_ovf;
  logic [CNT_W-1:0]       w_count [NUM_EVENTS];

  // The entry edge into RUN never counts because the registered state is
  // still IDLE on that edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_run_state <= IDLE;
    end else begin
      case (r_run_state)
        IDLE: begin
          if (start_i) r_run_state <= RUN;
        end
        RUN: begin
          if (!start_i)     r_run_state <= IDLE;
          else if (freeze_i) r_run_state <= FROZEN;
        end
        FROZEN: begin
          if (!start_i)      r_run_state <= IDLE;
          else if (!freeze_i) r_run_state <= RUN;
        end
        default: r_run_state <= IDLE;
      endcase
    end
  end

  assign w_count_en = (r_run_state == RUN) && !freeze_i;

  always_comb begin
    w_inc             = '0;
    w_inc[SEL_CYCLE]  = w_count_en;
    w_inc[SEL_STALL]  = w_count_en & is_load_use_stall(hazard_i, jump_i, branch_i);
    w_inc[SEL_FLUSH]  = w_count_en & flush_i;
    w_inc[SEL_RETIRE] = w_count_en & retire_i;
  end

  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_cnt
    perf_sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (w_inc[g]),
      .clr_i   (clear_i),
      .count_o (w_count[g]),
      .ovf_o   (w_ovf[g])
    );
  end

  // Snapshot samples the registered counts, so a read on edge N returns the
  // value from before that edge's increment or clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_state <= RD_IDLE;
      r_rd_ack   <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (rd_req_i) begin
            r_rd_data  <= w_count[rd_sel_i];
            r_rd_ack   <= 1'b1;
            r_rd_state <= RD_ACK;
          end
        end
        RD_ACK: begin
          r_rd_ack   <= 1'b0;
          r_rd_state <= RD_IDLE;
        end
        default: begin
          r_rd_ack   <= 1'b0;
          r_rd_state <= RD_IDLE;
        end
      endcase
    end
  end

  assign rd_ack_o   = r_rd_ack;
  assign rd_data_o  = r_rd_data;
  assign overflow_o = w_ovf;

endmodule

// File: tb/tb_perf_event_counter.sv
// Directed bench for perf_event_counter: a 32-bit instance for the main
// function and a 4-bit instance for saturation and clear.
module tb_perf_event_counter;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic        hazard_i;
  logic        jump_i;
  logic        branch_i;
  logic        flush_i;
  logic        retire_i;
  logic        freeze_i;
  logic        clear_i;
  logic        rd_req_i;
  logic [1:0]  rd_sel_i;
  logic        rd_ack_o;
  logic [31:0] rd_data_o;
  logic [3:0]  overflow_o;

  logic        startB;
  logic        clearB;
  logic        rdReqB;
  logic        rdAckB;
  logic [3:0]  rdDataB;
  logic [3:0]  overflowB;

  int nCompared;
  int nFailed;

  logic [9:0] hazPat;
  logic [9:0] brPat;
  logic [9:0] jmpPat;
  logic [9:0] retPat;

  perf_event_counter #(.CNT_W(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .hazard_i   (hazard_i),
    .jump_i     (jump_i),
    .branch_i   (branch_i),
    .flush_i    (flush_i),
    .retire_i   (retire_i),
    .freeze_i   (freeze_i),
    .clear_i    (clear_i),
    .rd_req_i   (rd_req_i),
    .rd_sel_i   (rd_sel_i),
    .rd_ack_o   (rd_ack_o),
    .rd_data_o  (rd_data_o),
    .overflow_o (overflow_o)
  );

  perf_event_counter #(.CNT_W(4)) dutSmall (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (startB),
    .hazard_i   (hazard_i),
    .jump_i     (jump_i),
    .branch_i   (branch_i),
    .flush_i    (flush_i),
    .retire_i   (retire_i),
    .freeze_i   (freeze_i),
    .clear_i    (clearB),
    .rd_req_i   (rdReqB),
    .rd_sel_i   (rd_sel_i),
    .rd_ack_o   (rdAckB),
    .rd_data_o  (rdDataB),
    .overflow_o (overflowB)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nFailed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic haz, input logic jmp, input logic br,
                               input logic fl, input logic ret);
    hazard_i = haz;
    jump_i   = jmp;
    branch_i = br;
    flush_i  = fl;
    retire_i = ret;
  endtask

  task automatic doRead(input logic [1:0] sel, input logic [31:0] exp, input string tag);
    rd_sel_i = sel;
    rd_req_i = 1'b1;
    step(1);
    checkOutput({tag, "_ack"}, {31'd0, rd_ack_o}, 32'd1);
    checkOutput({tag, "_data"}, rd_data_o, exp);
    rd_req_i = 1'b0;
    step(1);
  endtask

  task automatic doReadB(input logic [1:0] sel, input logic [31:0] exp, input string tag);
    rd_sel_i = sel;
    rdReqB   = 1'b1;
    step(1);
    checkOutput({tag, "_ack"}, {31'd0, rdAckB}, 32'd1);
    checkOutput({tag, "_data"}, {28'd0, rdDataB}, exp);
    rdReqB = 1'b0;
    step(1);
  endtask

  initial begin
    nCompared = 0;
    nFailed   = 0;
    rst_i     = 1'b0;
    start_i   = 1'b0;
    startB    = 1'b0;
    clearB    = 1'b0;
    rdReqB    = 1'b0;
    freeze_i  = 1'b0;
    clear_i   = 1'b0;
    rd_req_i  = 1'b0;
    rd_sel_i  = 2'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset and idle with all events active
    step(2);
    checkOutput("rst_ack", {31'd0, rd_ack_o}, 32'd0);
    checkOutput("rst_data", rd_data_o, 32'd0);
    checkOutput("rst_ovf", {28'd0, overflow_o}, 32'd0);
    rst_i = 1'b1;
    step(5);
    checkOutput("idle_ovf", {28'd0, overflow_o}, 32'd0);
    checkOutput("idle_ack", {31'd0, rd_ack_o}, 32'd0);
    doRead(2'd0, 32'd0, "idle_cycle");
    doRead(2'd1, 32'd0, "idle_stall");
    doRead(2'd2, 32'd0, "idle_flush");
    doRead(2'd3, 32'd0, "idle_retire");

    // Ten counted edges with a stall pattern; branch/jump edges must not count
    hazPat = 10'b0000111101;
    brPat  = 10'b0000001000;
    jmpPat = 10'b0000100000;
    retPat = 10'b0001000010;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start_i = 1'b1;
    step(1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(hazPat[i], jmpPat[i], brPat[i], 1'b0, retPat[i]);
      step(1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    freeze_i = 1'b1;
    step(1);
    doRead(2'd0, 32'd10, "run_cycle");
    doRead(2'd1, 32'd3, "run_stall");
    doRead(2'd2, 32'd0, "run_flush");
    doRead(2'd3, 32'd2, "run_retire");

    // Flush pulses, one coincident with a counted stall
    freeze_i = 1'b0;
    step(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    freeze_i = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    doRead(2'd0, 32'd12, "flush_cycle");
    doRead(2'd1, 32'd4, "flush_stall");
    doRead(2'd2, 32'd2, "flush_flush");
    doRead(2'd3, 32'd2, "frozen_retire");
    checkOutput("run_ovf", {28'd0, overflow_o}, 32'd0);

    // Read while counting returns the pre-edge value; request during ack ignored
    freeze_i = 1'b0;
    step(1);
    hazard_i = 1'b1;
    rd_sel_i = 2'd1;
    rd_req_i = 1'b1;
    step(1);
    checkOutput("live_ack", {31'd0, rd_ack_o}, 32'd1);
    checkOutput("live_data", rd_data_o, 32'd4);
    step(1);
    checkOutput("ignored_ack", {31'd0, rd_ack_o}, 32'd0);
    checkOutput("held_data", rd_data_o, 32'd4);
    rd_req_i = 1'b0;
    hazard_i = 1'b0;
    freeze_i = 1'b1;
    step(1);
    doRead(2'd1, 32'd6, "live_stall");
    doRead(2'd0, 32'd14, "live_cycle");

    // Clear concurrent with read returns pre-clear value; FSM state retained
    clear_i  = 1'b1;
    rd_sel_i = 2'd0;
    rd_req_i = 1'b1;
    step(1);
    clear_i  = 1'b0;
    rd_req_i = 1'b0;
    checkOutput("clr_rd_ack", {31'd0, rd_ack_o}, 32'd1);
    checkOutput("clr_rd_data", rd_data_o, 32'd14);
    step(1);
    doRead(2'd0, 32'd0, "clr_cycle");
    doRead(2'd2, 32'd0, "clr_flush");
    freeze_i = 1'b0;
    step(4);
    freeze_i = 1'b1;
    step(1);
    doRead(2'd0, 32'd3, "post_clr_cycle");

    // Async reset mid-run drops a pending ack and restarts counting
    freeze_i = 1'b0;
    step(3);
    rd_sel_i = 2'd0;
    rd_req_i = 1'b1;
    step(1);
    checkOutput("pre_rst_ack", {31'd0, rd_ack_o}, 32'd1);
    checkOutput("pre_rst_data", rd_data_o, 32'd5);
    #2;
    rst_i = 1'b0;
    #1;
    checkOutput("midrst_ack", {31'd0, rd_ack_o}, 32'd0);
    checkOutput("midrst_data", rd_data_o, 32'd0);
    rd_req_i = 1'b0;
    #2;
    rst_i = 1'b1;
    step(3);
    freeze_i = 1'b1;
    step(1);
    doRead(2'd0, 32'd2, "restart_cycle");

    // Saturation on the 4-bit instance, then clear while leaving RUN
    start_i  = 1'b0;
    freeze_i = 1'b0;
    startB   = 1'b1;
    step(1);
    step(15);
    checkOutput("sat_noovf", {28'd0, overflowB}, 32'd0);
    step(1);
    checkOutput("sat_ovf", {28'd0, overflowB}, 32'd1);
    step(4);
    checkOutput("sat_ovf_sticky", {28'd0, overflowB}, 32'd1);
    startB = 1'b0;
    step(1);
    doReadB(2'd0, 32'd15, "sat_cycle");
    clearB = 1'b1;
    step(1);
    clearB = 1'b0;
    checkOutput("clr_ovf", {28'd0, overflowB}, 32'd0);
    doReadB(2'd0, 32'd0, "sat_clr_cycle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
